// File: rtl/execute_retire_pkg.sv
// -----------------------------------------------------------------------------
// execute_retire_pkg
// Shared instruction-level definitions used by the execute/retire stage:
//   - architectural flag bit positions inside the packed flag register
//   - bit positions of the flag-update enable vector {upd_zn, upd_c}
//   - occupancy encoding of the 2-entry writeback skid buffer
// -----------------------------------------------------------------------------
package execute_retire_pkg;

    // Architectural flag register layout
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

    // Flag-update enable vector layout
    localparam int UPD_C  = 0;
    localparam int UPD_ZN = 1;
    localparam int UPD_W  = 2;

    typedef logic [FLAG_W-1:0] flags_t;
    typedef logic [UPD_W-1:0]  flag_upd_t;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/execute_retire_skid.sv
// -----------------------------------------------------------------------------
// execute_retire_skid
// Generic 2-entry valid/ready skid buffer. Main register M drives the output,
// skid register S absorbs the one extra beat that may arrive while the
// consumer stalls. in_ready is a flop derived from next occupancy only, so
// there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         drop all buffered entries on the next edge
//   in_valid      push request (already qualified by the caller)
//   in_ready      buffer can accept (registered)
//   in_payload    pushed payload
//   out_valid     M holds a valid entry
//   out_ready     consumer takes M this cycle
//   out_payload   contents of M (held stable while stalled)
// -----------------------------------------------------------------------------
module execute_retire_skid
    import execute_retire_pkg::*;
#(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    occ_e         occ_p1;
    occ_e         occ_nxt;
    logic         rdy_p1;
    logic [W-1:0] m_p1;
    logic [W-1:0] s_p1;

    logic push;
    logic pop;
    logic m_load_new;
    logic m_load_skid;
    logic s_load;

    assign push        = in_valid & rdy_p1;
    assign pop         = out_valid & out_ready;
    assign in_ready    = rdy_p1;
    assign out_valid   = (occ_p1 != OCC_EMPTY);
    assign out_payload = m_p1;

    // Occupancy / in_ready register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_p1 <= OCC_EMPTY;
            rdy_p1 <= 1'b1;
        end else begin
            occ_p1 <= occ_nxt;
            rdy_p1 <= (occ_nxt != OCC_TWO);
        end
    end

    always_comb begin
        occ_nxt     = occ_p1;
        m_load_new  = 1'b0;
        m_load_skid = 1'b0;
        s_load      = 1'b0;
        case (occ_p1)
            OCC_EMPTY: begin
                if (push) begin
                    occ_nxt    = OCC_ONE;
                    m_load_new = 1'b1;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    m_load_new = 1'b1;      // pass-through, occupancy unchanged
                end else if (push) begin
                    occ_nxt = OCC_TWO;
                    s_load  = 1'b1;
                end else if (pop) begin
                    occ_nxt = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // rdy_p1 is low here, so push cannot occur
                if (pop) begin
                    occ_nxt     = OCC_ONE;
                    m_load_skid = 1'b1;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
        // Flush wins over everything; stale data may remain in M/S but is invalid
        if (flush) begin
            occ_nxt     = OCC_EMPTY;
            m_load_new  = 1'b0;
            m_load_skid = 1'b0;
            s_load      = 1'b0;
        end
    end

    // Payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p1 <= '0;
            s_p1 <= '0;
        end else begin
            if (m_load_new) begin
                m_p1 <= in_payload;
            end else if (m_load_skid) begin
                m_p1 <= s_p1;
            end
            if (s_load) begin
                s_p1 <= in_payload;
            end
        end
    end

endmodule

// File: rtl/execute_retire.sv
// -----------------------------------------------------------------------------
// execute_retire
// Stage after the adder/ALU execute units. Owns the architectural C/Z/N flag
// register (C is fed back to the adder carry input) and buffers results for
// register-file writeback through a 2-entry skid buffer.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            execute result handshake (in_ready registered)
//   in_data, in_carry            result and adder carry out
//   in_rd, in_we                 destination register and write enable
//   in_upd_c, in_upd_zn          flag update enables
//   flush                        discard buffered, not-yet-retired entries
//   wb_valid/wb_ready            writeback handshake
//   wb_rd, wb_data               writeback register and data
//   flag_c, flag_z, flag_n       architectural flags
// -----------------------------------------------------------------------------
module execute_retire
    import execute_retire_pkg::*;
#(
    parameter int LEN_REG      = 32,
    parameter int LEN_REG_ADDR = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEN_REG-1:0]      in_data,
    input  logic                    in_carry,
    input  logic [LEN_REG_ADDR-1:0] in_rd,
    input  logic                    in_we,
    input  logic                    in_upd_c,
    input  logic                    in_upd_zn,
    input  logic                    flush,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [LEN_REG_ADDR-1:0] wb_rd,
    output logic [LEN_REG-1:0]      wb_data,
    output logic                    flag_c,
    output logic                    flag_z,
    output logic                    flag_n
);

    localparam int PAYLOAD_W = LEN_REG_ADDR + LEN_REG;

    logic           accept;
    logic           push_vld;
    flag_upd_t      upd;
    flags_t         flags_p1;
    logic [PAYLOAD_W-1:0] wb_payload;

    function automatic flags_t next_flags(
        input flags_t               cur,
        input logic [LEN_REG-1:0]   data,
        input logic                 carry,
        input flag_upd_t            en
    );
        flags_t f;
        f = cur;
        if (en[UPD_C]) begin
            f[FLAG_C] = carry;
        end
        if (en[UPD_ZN]) begin
            f[FLAG_Z] = (data == '0);
            f[FLAG_N] = data[LEN_REG-1];
        end
        return f;
    endfunction

    assign accept = in_valid & in_ready;
    assign upd    = {in_upd_zn, in_upd_c};
    // CMP-style results (in_we=0) and beats accepted under flush never enqueue
    assign push_vld = in_valid & in_we & ~flush;

    // Flag register: updated on every accepted beat, flush does not matter here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_p1 <= '0;
        end else if (accept) begin
            flags_p1 <= next_flags(flags_p1, in_data, in_carry, upd);
        end
    end

    assign flag_c = flags_p1[FLAG_C];
    assign flag_z = flags_p1[FLAG_Z];
    assign flag_n = flags_p1[FLAG_N];

    // Writeback buffer
    execute_retire_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (push_vld),
        .in_ready    (in_ready),
        .in_payload  ({in_rd, in_data}),
        .out_valid   (wb_valid),
        .out_ready   (wb_ready),
        .out_payload (wb_payload)
    );

    assign {wb_rd, wb_data} = wb_payload;

endmodule

// File: tb/tb_execute_retire.sv
module tb_execute_retire;

    localparam int LR = 32;
    localparam int LA = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LR-1:0] in_data;
    logic          in_carry;
    logic [LA-1:0] in_rd;
    logic          in_we;
    logic          in_upd_c;
    logic          in_upd_zn;
    logic          flush;
    logic          wb_valid;
    logic          wb_ready;
    logic [LA-1:0] wb_rd;
    logic [LR-1:0] wb_data;
    logic          flag_c;
    logic          flag_z;
    logic          flag_n;

    execute_retire #(.LEN_REG(LR), .LEN_REG_ADDR(LA)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_upd_c  (in_upd_c),
        .in_upd_zn (in_upd_zn),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of pending writebacks plus architectural flags
    logic [LA+LR-1:0] mq[$];
    logic             mc, mz, mn;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        check_val("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check_val("wb_valid", 64'(wb_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_val("wb_rd",   64'(wb_rd),   64'(mq[0][LA+LR-1:LR]));
            check_val("wb_data", 64'(wb_data), 64'(mq[0][LR-1:0]));
        end
        check_val("flag_c", 64'(flag_c), 64'(mc));
        check_val("flag_z", 64'(flag_z), 64'(mz));
        check_val("flag_n", 64'(flag_n), 64'(mn));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), advance the
    // model by one edge and compare #1 after that edge.
    task automatic step(input logic v, input logic [LR-1:0] d, input logic c,
                        input logic [LA-1:0] rd, input logic we, input logic uc,
                        input logic uzn, input logic fl, input logic wr);
        logic acc, pop;
        in_valid = v; in_data = d; in_carry = c; in_rd = rd; in_we = we;
        in_upd_c = uc; in_upd_zn = uzn; flush = fl; wb_ready = wr;
        acc = v && (mq.size() < 2);
        pop = wr && (mq.size() > 0);
        @(posedge clk);
        if (acc) begin
            if (uc) mc = c;
            if (uzn) begin
                mz = (d == 0);
                mn = d[LR-1];
            end
        end
        if (pop) mq.delete(0);
        if (acc && we && !fl) mq.push_back({rd, d});
        if (fl) mq.delete();
        #1;
        compare_model();
    endtask

    task automatic idle(input logic wr);
        step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, wr);
    endtask

    task automatic model_reset();
        mq.delete();
        mc = 1'b0; mz = 1'b0; mn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_carry = 0; in_rd = 0; in_we = 0;
        in_upd_c = 0; in_upd_zn = 0; flush = 0; wb_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_wb_data",  64'(wb_data),  64'd0);
        check_val("rst_wb_rd",    64'(wb_rd),    64'd0);
        check_val("rst_flags",    64'({flag_c, flag_z, flag_n}), 64'd0);
        rst = 1'b0;

        // Zero result with carry
        step(1'b1, 32'h0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("zero_wb_valid", 64'(wb_valid), 64'd1);
        check_val("zero_wb_data",  64'(wb_data),  64'd0);
        check_val("zero_flags",    64'({flag_c, flag_z, flag_n}), 64'b110);
        idle(1'b1);

        // ADC chain
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("adc0_c",    64'(flag_c),  64'd1);
        check_val("adc0_n",    64'(flag_n),  64'd1);
        check_val("adc0_data", 64'(wb_data), 64'hFFFF_FFFF);
        step(1'b1, 32'h0000_0001, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("adc1_c",    64'(flag_c),  64'd0);
        check_val("adc1_n",    64'(flag_n),  64'd0);
        check_val("adc1_data", 64'(wb_data), 64'h1);
        idle(1'b1);

        // Backpressure: third beat must be refused
        step(1'b1, 32'hA, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bp_in_ready_lo", 64'(in_ready), 64'd0);
        step(1'b1, 32'hC, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bp_hold_data", 64'(wb_data), 64'hA);
        idle(1'b1);
        check_val("bp_drain1", 64'(wb_data), 64'hB);
        check_val("bp_in_ready_hi", 64'(in_ready), 64'd1);
        idle(1'b1);
        check_val("bp_empty", 64'(wb_valid), 64'd0);

        // CMP: flags only
        step(1'b1, 32'h8000_0000, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("cmp_wb_valid", 64'(wb_valid), 64'd0);
        check_val("cmp_flags",    64'({flag_c, flag_z, flag_n}), 64'b001);

        // Flush while TWO with C=1
        step(1'b1, 32'h5, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("fl_two", 64'(in_ready), 64'd0);
        idle(1'b0);
        flush = 1'b1;
        @(posedge clk);
        mq.delete();
        #1;
        flush = 1'b0;
        check_val("fl_wb_valid", 64'(wb_valid), 64'd0);
        check_val("fl_in_ready", 64'(in_ready), 64'd1);
        check_val("fl_flag_c",   64'(flag_c),   64'd1);

        // Accept during flush: flags update, no enqueue
        step(1'b1, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("flacc_wb_valid", 64'(wb_valid), 64'd0);
        check_val("flacc_flags", 64'({flag_c, flag_z, flag_n}), 64'b010);

        // Asynchronous reset while TWO
        step(1'b1, 32'h8000_0011, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("arst_flags",    64'({flag_c, flag_z, flag_n}), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [LR-1:0] d;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)      d = 32'h0;
            else if (sel == 1) d = 32'h8000_0000;
            else               d = $urandom;
            step(($urandom_range(0, 3) != 0), d, 1'($urandom),
                 5'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
